rf_wport_sched: RTL and testbench
=================================

Name: rf_wport_sched

Overview:
- Schedules the single write port of the 32x32 register file between two producers: the in-order WB stage and an out-of-band multi-cycle MUL/DIV unit (MDU).
- Keeps a per-register busy scoreboard for outstanding MDU results and stalls ID on hazards against them.
- Breaks WB-vs-MDU starvation with a bounded wait counter that freezes the pipeline for one cycle.
- Sits between the WB stage, the MDU and the register file; drives the register file's write inputs directly.

Parameters:
- WIDTH, 32, data width.
- DEPTH_B, 5, register address width.
- MAX_OUT, 4, maximum outstanding MDU operations (1..15).
- STARVE_MAX, 3, number of consecutive cycles an MDU result may lose arbitration before the pipeline is frozen (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wb_we  in  1  WB stage write request.
- wb_wa  in  DEPTH_B  WB write address.
- wb_wd  in  WIDTH  WB write data.
- mdu_iss_valid  in  1  ID issues an MDU op this cycle.
- mdu_iss_rd  in  DEPTH_B  destination register of the issued op.
- mdu_iss_ready  out  1  count < MAX_OUT.
- mdu_res_valid  in  1  MDU result available.
- mdu_res_rd  in  DEPTH_B  result destination register.
- mdu_res_wd  in  WIDTH  result data.
- mdu_res_ready  out  1  result accepted this cycle.
- id_ra0  in  DEPTH_B  ID source register 0.
- id_ra1  in  DEPTH_B  ID source register 1.
- id_wa  in  DEPTH_B  ID destination register.
- id_we  in  1  ID instruction writes a register.
- id_hazard  out  1  ID must stall.
- pipe_freeze  out  1  freeze IF..WB for one cycle.
- rf_we  out  1  to register file rf_we.
- rf_wa  out  DEPTH_B  to register file rf_wa.
- rf_wd  out  WIDTH  to register file rf_wd.

Behaviour:
- Reset: busy all 0; out_cnt 0; starve_cnt 0; state ARB. With no requests, all outputs are 0 except mdu_iss_ready=1.
- Write-port mux is combinational (0 latency); the register file's internal bypass makes the write visible to same-cycle reads.
- FSM state ARB:
  - wb_we=1 → WB owns the port; mdu_res_ready=0.
  - Otherwise, mdu_res_valid=1 → MDU owns the port; mdu_res_ready=1.
  - starve_cnt increments when mdu_res_valid=1 and the MDU loses; it clears to 0 on acceptance or when mdu_res_valid=0.
  - Reaching starve_cnt==STARVE_MAX → go to DRAIN.
- FSM state DRAIN (exactly 1 cycle):
  - pipe_freeze=1, which forces WB to hold, so its wb_we is ignored this cycle.
  - MDU owns the port; mdu_res_ready=1; starve_cnt clears to 0.
  - Next state ARB.
- mdu_res_valid dropping in DRAIN: this is illegal. The block still returns to ARB with the port idle.
- Scoreboard:
  - A handshake on mdu_iss_valid && mdu_iss_ready sets busy[mdu_iss_rd].
  - An accepted result clears busy[mdu_res_rd].
  - Same-cycle set and clear of the same register: set wins.
  - Register 0 is never marked busy.
- out_cnt: +1 on issue, -1 on accepted result; both in the same cycle → unchanged. It never exceeds MAX_OUT. An issue when mdu_iss_ready=0 is ignored.
- id_hazard = busy[id_ra0] | busy[id_ra1] | (id_we & busy[id_wa]) (WAW), all evaluated on registered busy.
  - A result accepted this cycle does not clear the hazard until the next cycle.
  - Address 0 never causes a hazard.
- rf_we=0 whenever the selected write address is 0; the port is still consumed.
- Reset asserted mid-operation: all state clears next edge, including in DRAIN. Pending MDU results are discarded; the MDU must be reset together with this block.

Optional Feature:
- RF_SCHED_PERF_EN defined:
  - Adds outputs perf_conflict (32-bit; count of cycles where wb_we and mdu_res_valid are both 1) and perf_freeze (32-bit; count of DRAIN cycles).
  - Both counters clear on rst and saturate at all-ones.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: ARB=1'b0, DRAIN=1'b1.
  - Constant REG_ZERO = 5'd0.
  - Default widths WIDTH/DEPTH_B.
- Natural sub-module: rf_busy_scoreboard, containing the busy vector, set/clear priority and the 3 hazard lookups. The top keeps arbitration, out_cnt and the FSM.

Test Plan:
- Lone WB write wb_we=1, wb_wa=5, wb_wd=0xDEAD → same cycle rf_we=1, rf_wa=5, rf_wd=0xDEAD; mdu_res_ready=0.
- Issue rd=7 at cycle 0; ID reads ra0=7 at cycle 1 → id_hazard=1. Result 0x1234 accepted at cycle 4 → rf_wa=7, rf_wd=0x1234; id_hazard=0 from cycle 5.
- Starvation: wb_we held 1 with mdu_res_valid=1, STARVE_MAX=3 → cycles 1-3 WB wins, cycle 4 pipe_freeze=1 and MDU written, cycle 5 back to ARB.
- Issue 4 ops without results → mdu_iss_ready=0 after the 4th; a 5th issue is ignored (busy unchanged). One result accepted → ready=1 next cycle.
- Same-cycle issue rd=9 and accepted result rd=9 → busy[9] stays 1, out_cnt unchanged. Issue rd=0 → busy[0] stays 0; its result gives rf_we=0.
- Assert rst during DRAIN → next cycle state ARB, pipe_freeze=0, busy=0, mdu_iss_ready=1.

Source files
------------

// File: rtl/rf_wport_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_wport_sched_pkg : shared FSM encoding, register-zero constant and default
//                      widths for the register-file write-port scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
package rf_wport_sched_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH_B = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    DRAIN = 1'b1
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_wport_sched_busy.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_busy_scoreboard : per-register busy bits for outstanding MDU results and
//                      the three ID hazard lookups (two sources plus WAW).
// Rev 1.0
// ----------------------------------------------------------------------------
module rf_busy_scoreboard
  import rf_wport_sched_pkg::*;
#(
  parameter int DEPTH_B = DEF_DEPTH_B
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [DEPTH_B-1:0] set_rd,
  input  logic               clr_en,
  input  logic [DEPTH_B-1:0] clr_rd,
  input  logic [DEPTH_B-1:0] ra0,
  input  logic [DEPTH_B-1:0] ra1,
  input  logic [DEPTH_B-1:0] wa,
  input  logic               we,
  output logic               hazard
);

  localparam int                 NREG   = 2 ** DEPTH_B;
  localparam logic [DEPTH_B-1:0] ZERO_A = DEPTH_B'(REG_ZERO);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a same-cycle issue to the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_rd] = 1'b0;
    if (set_en && (set_rd != ZERO_A)) busy_d[set_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign hazard = busy_q[ra0] | busy_q[ra1] | (we & busy_q[wa]);

endmodule
`default_nettype wire

// File: rtl/rf_wport_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_wport_sched : arbitrates the register-file write port between WB and the
//                  MDU, with starvation drain. Optional: RF_SCHED_PERF_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module rf_wport_sched
  import rf_wport_sched_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_B    = DEF_DEPTH_B,
  parameter int MAX_OUT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_we,
  input  logic [DEPTH_B-1:0] wb_wa,
  input  logic [WIDTH-1:0]   wb_wd,
  input  logic               mdu_iss_valid,
  input  logic [DEPTH_B-1:0] mdu_iss_rd,
  output logic               mdu_iss_ready,
  input  logic               mdu_res_valid,
  input  logic [DEPTH_B-1:0] mdu_res_rd,
  input  logic [WIDTH-1:0]   mdu_res_wd,
  output logic               mdu_res_ready,
  input  logic [DEPTH_B-1:0] id_ra0,
  input  logic [DEPTH_B-1:0] id_ra1,
  input  logic [DEPTH_B-1:0] id_wa,
  input  logic               id_we,
  output logic               id_hazard,
  output logic               pipe_freeze,
  output logic               rf_we,
  output logic [DEPTH_B-1:0] rf_wa,
  output logic [WIDTH-1:0]   rf_wd
`ifdef RF_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_conflict,
  output logic [31:0]        perf_freeze
`endif
);

  localparam int                 CNT_W     = 4;
  localparam logic [CNT_W-1:0]   MAX_OUT_C = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0]   STARVE_C  = CNT_W'(STARVE_MAX);
  localparam logic [DEPTH_B-1:0] ZERO_A    = DEPTH_B'(REG_ZERO);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             wb_sel, mdu_sel, iss_fire, res_dec;

  always_comb begin
    wb_sel        = 1'b0;
    mdu_sel       = 1'b0;
    rf_we         = 1'b0;
    rf_wa         = '0;
    rf_wd         = '0;
    mdu_iss_ready = (out_cnt_q < MAX_OUT_C);
    pipe_freeze   = (state_q == DRAIN);
    starve_d      = starve_q;
    state_d       = state_q;
    out_cnt_d     = out_cnt_q;

    // In DRAIN the pipeline is frozen, so WB's request is disregarded.
    if (state_q == DRAIN) mdu_sel = mdu_res_valid;
    else if (wb_we)       wb_sel  = 1'b1;
    else                  mdu_sel = mdu_res_valid;

    if (wb_sel) begin
      rf_wa = wb_wa;
      rf_wd = wb_wd;
    end else if (mdu_sel) begin
      rf_wa = mdu_res_rd;
      rf_wd = mdu_res_wd;
    end
    rf_we         = (wb_sel | mdu_sel) & (rf_wa != ZERO_A);
    mdu_res_ready = mdu_sel;

    iss_fire = mdu_iss_valid & mdu_iss_ready;
    res_dec  = mdu_sel & (out_cnt_q != '0);
    if (iss_fire && !res_dec)      out_cnt_d = out_cnt_q + 1'b1;
    else if (!iss_fire && res_dec) out_cnt_d = out_cnt_q - 1'b1;

    if (state_q == DRAIN) begin
      starve_d = '0;
      state_d  = ARB;
    end else begin
      if (mdu_res_valid && !mdu_sel) starve_d = starve_q + 1'b1;
      else                           starve_d = '0;
      if (starve_d == STARVE_C) state_d = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      starve_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  rf_busy_scoreboard #(
    .DEPTH_B (DEPTH_B)
  ) u_busy (
    .clk    (clk),
    .rst    (rst),
    .set_en (iss_fire),
    .set_rd (mdu_iss_rd),
    .clr_en (mdu_sel),
    .clr_rd (mdu_res_rd),
    .ra0    (id_ra0),
    .ra1    (id_ra1),
    .wa     (id_wa),
    .we     (id_we),
    .hazard (id_hazard)
  );

`ifdef RF_SCHED_PERF_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_freeze_q, perf_freeze_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q;
    perf_freeze_d   = perf_freeze_q;
    if (wb_we && mdu_res_valid && !(&perf_conflict_q)) perf_conflict_d = perf_conflict_q + 1'b1;
    if (pipe_freeze && !(&perf_freeze_q))              perf_freeze_d   = perf_freeze_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_q <= '0;
      perf_freeze_q   <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_freeze_q   <= perf_freeze_d;
    end
  end

  assign perf_conflict = perf_conflict_q;
  assign perf_freeze   = perf_freeze_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_rf_wport_sched : directed vector table, corner sequences and a randomized
//                     run against a queue-based reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rf_wport_sched;

  localparam int MAX_OUT    = 4;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        mdu_iss_valid;
  logic [4:0]  mdu_iss_rd;
  logic        mdu_iss_ready;
  logic        mdu_res_valid;
  logic [4:0]  mdu_res_rd;
  logic [31:0] mdu_res_wd;
  logic        mdu_res_ready;
  logic [4:0]  id_ra0, id_ra1, id_wa;
  logic        id_we;
  logic        id_hazard;
  logic        pipe_freeze;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  rf_wport_sched #(
    .WIDTH(32), .DEPTH_B(5), .MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .mdu_iss_valid(mdu_iss_valid), .mdu_iss_rd(mdu_iss_rd), .mdu_iss_ready(mdu_iss_ready),
    .mdu_res_valid(mdu_res_valid), .mdu_res_rd(mdu_res_rd), .mdu_res_wd(mdu_res_wd),
    .mdu_res_ready(mdu_res_ready),
    .id_ra0(id_ra0), .id_ra1(id_ra1), .id_wa(id_wa), .id_we(id_we),
    .id_hazard(id_hazard), .pipe_freeze(pipe_freeze),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  typedef struct {
    logic wb_we; logic [4:0] wb_wa; logic [31:0] wb_wd;
    logic iv; logic [4:0] ird;
    logic rv; logic [4:0] rrd; logic [31:0] rwd;
    logic [4:0] ra0, ra1, iwa; logic iwe;
  } in_t;

  typedef struct {
    logic rf_we; logic [4:0] rf_wa; logic [31:0] rf_wd;
    logic rres; logic riss; logic hz; logic fr;
  } out_t;

  typedef struct { in_t i; out_t o; } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t V(bit wbwe, bit [4:0] wbwa, bit [31:0] wbwd,
                             bit iv, bit [4:0] ird,
                             bit rv, bit [4:0] rrd, bit [31:0] rwd,
                             bit [4:0] ra0, bit [4:0] ra1, bit [4:0] iwa, bit iwe,
                             bit ewe, bit [4:0] ewa, bit [31:0] ewd,
                             bit erdy, bit eirdy, bit ehz, bit efr);
    vec_t v;
    v.i = '{wbwe, wbwa, wbwd, iv, ird, rv, rrd, rwd, ra0, ra1, iwa, iwe};
    v.o = '{ewe, ewa, ewd, erdy, eirdy, ehz, efr};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t x);
    wb_we = x.wb_we; wb_wa = x.wb_wa; wb_wd = x.wb_wd;
    mdu_iss_valid = x.iv; mdu_iss_rd = x.ird;
    mdu_res_valid = x.rv; mdu_res_rd = x.rrd; mdu_res_wd = x.rwd;
    id_ra0 = x.ra0; id_ra1 = x.ra1; id_wa = x.iwa; id_we = x.iwe;
  endtask

  task automatic check_outs(input string tag, input out_t e);
    chk({tag, ".rf_we"},         32'(rf_we),         32'(e.rf_we));
    chk({tag, ".rf_wa"},         32'(rf_wa),         32'(e.rf_wa));
    chk({tag, ".rf_wd"},         rf_wd,              e.rf_wd);
    chk({tag, ".mdu_res_ready"}, 32'(mdu_res_ready), 32'(e.rres));
    chk({tag, ".mdu_iss_ready"}, 32'(mdu_iss_ready), 32'(e.riss));
    chk({tag, ".id_hazard"},     32'(id_hazard),     32'(e.hz));
    chk({tag, ".pipe_freeze"},   32'(pipe_freeze),   32'(e.fr));
  endtask

  // One clock: drive after the edge, sample mid-cycle, then step past the next edge.
  task automatic cyc(input vec_t v, input string tag);
    drive(v.i);
    #4;
    check_outs(tag, v.o);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vec_t z;
    z = V(0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,1,0,0);
    rst = 1'b1;
    drive(z.i);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issue rd=6, then hold WB and the rd=6 result together for STARVE_MAX losing cycles.
  task automatic starve_up(input string tag);
    do_reset();
    cyc(V(0,0,0, 1,6, 0,0,0, 0,0,0,0, 0,0,0, 0,1,0,0), {tag, ".iss"});
    for (int k = 1; k <= STARVE_MAX; k++)
      cyc(V(1,2,'h22, 0,0, 1,6,'h66, 6,0,0,0, 1,2,'h22, 0,1,1,0), $sformatf("%s.lose%0d", tag, k));
  endtask

  vec_t tbl[19];

  // Reference model state
  bit          m_busy[32];
  int          m_cnt, m_starve;
  bit          m_drain;
  int          q[$];
  bit          pend;
  logic [4:0]  p_rd;
  logic [31:0] p_wd;

  task automatic model_clear();
    foreach (m_busy[r]) m_busy[r] = 1'b0;
    m_cnt = 0; m_starve = 0; m_drain = 1'b0;
    q.delete();
    pend = 1'b0;
  endtask

  initial begin
    vec_t        v;
    int          own;
    bit          do_rst, acc, iss_ok;

    rst = 1'b1;
    tbl[0]  = V(0,0,0,       0,0, 0,0,0,       0,0,0,0, 0,0,0,       0,1,0,0);
    tbl[1]  = V(1,5,'hDEAD,  0,0, 0,0,0,       0,0,0,0, 1,5,'hDEAD,  0,1,0,0);
    tbl[2]  = V(0,0,0,       1,7, 0,0,0,       0,0,0,0, 0,0,0,       0,1,0,0);
    tbl[3]  = V(0,0,0,       0,0, 0,0,0,       7,0,0,0, 0,0,0,       0,1,1,0);
    tbl[4]  = V(0,0,0,       0,0, 0,0,0,       0,7,0,0, 0,0,0,       0,1,1,0);
    tbl[5]  = V(0,0,0,       0,0, 0,0,0,       0,0,7,1, 0,0,0,       0,1,1,0);
    tbl[6]  = V(0,0,0,       0,0, 0,0,0,       0,0,7,0, 0,0,0,       0,1,0,0);
    tbl[7]  = V(0,0,0,       0,0, 1,7,'h1234,  7,0,0,0, 1,7,'h1234,  1,1,1,0);
    tbl[8]  = V(0,0,0,       0,0, 0,0,0,       7,0,0,0, 0,0,0,       0,1,0,0);
    tbl[9]  = V(0,0,0,       1,0, 0,0,0,       0,0,0,0, 0,0,0,       0,1,0,0);
    tbl[10] = V(0,0,0,       0,0, 1,0,'h55,    0,0,0,0, 0,0,'h55,    1,1,0,0);
    tbl[11] = V(0,0,0,       1,9, 0,0,0,       0,0,0,0, 0,0,0,       0,1,0,0);
    tbl[12] = V(0,0,0,       1,9, 1,9,'h99,    0,0,0,0, 1,9,'h99,    1,1,0,0);
    tbl[13] = V(0,0,0,       0,0, 0,0,0,       9,0,0,0, 0,0,0,       0,1,1,0);
    tbl[14] = V(0,0,0,       0,0, 1,9,'h77,    0,9,0,0, 1,9,'h77,    1,1,1,0);
    tbl[15] = V(0,0,0,       1,4, 0,0,0,       9,0,0,0, 0,0,0,       0,1,0,0);
    tbl[16] = V(1,3,'h33,    0,0, 1,4,'h44,    0,0,0,0, 1,3,'h33,    0,1,0,0);
    tbl[17] = V(0,0,0,       0,0, 1,4,'h44,    0,0,4,1, 1,4,'h44,    1,1,1,0);
    tbl[18] = V(0,0,0,       0,0, 0,0,0,       0,0,4,1, 0,0,0,       0,1,0,0);

    drive(tbl[0].i);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (tbl[k]) cyc(tbl[k], $sformatf("vec%0d", k));

    // Starvation: three losses, one DRAIN cycle, then back to WB ownership.
    starve_up("starve");
    cyc(V(1,2,'h22, 0,0, 1,6,'h66, 6,0,0,0, 1,6,'h66, 1,1,1,1), "starve.drain");
    cyc(V(1,2,'h22, 0,0, 0,0,0,    6,0,0,0, 1,2,'h22, 0,1,0,0), "starve.after");

    // Result dropped during DRAIN: port idle, still one freeze cycle.
    starve_up("drop");
    cyc(V(1,2,'h22, 0,0, 0,0,0, 6,0,0,0, 0,0,0, 0,1,1,1), "drop.drain");
    cyc(V(0,0,0,    0,0, 0,0,0, 6,0,0,0, 0,0,0, 0,1,1,0), "drop.after");

    // Reset asserted in DRAIN clears everything at the next edge.
    starve_up("rstdrain");
    rst = 1'b1;
    cyc(V(1,2,'h22, 0,0, 1,6,'h66, 6,0,0,0, 1,6,'h66, 1,1,1,1), "rstdrain.drain");
    rst = 1'b0;
    cyc(V(0,0,0, 0,0, 0,0,0, 6,0,0,0, 0,0,0, 0,1,0,0), "rstdrain.after");

    // Outstanding limit: four issues fill it, a fifth is ignored.
    do_reset();
    for (int k = 1; k <= MAX_OUT; k++)
      cyc(V(0,0,0, 1,5'(k), 0,0,0, 0,0,0,0, 0,0,0, 0,1,0,0), $sformatf("full.iss%0d", k));
    cyc(V(0,0,0, 1,10, 0,0,0,    1,0,0,0, 0,0,0,    0,0,1,0), "full.extra");
    cyc(V(0,0,0, 0,0,  1,1,'h11, 10,0,0,0, 1,1,'h11, 1,0,0,0), "full.ret");
    cyc(V(0,0,0, 0,0,  0,0,0,    1,0,0,0, 0,0,0,    0,1,0,0), "full.ready");

    // Randomized run against the reference model.
    do_reset();
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      v.i.wb_we = 1'($urandom_range(0, 1));
      v.i.wb_wa = 5'($urandom);
      v.i.wb_wd = $urandom;
      v.i.iv    = ($urandom_range(0, 3) == 0);
      v.i.ird   = 5'($urandom_range(0, 7));
      if (!pend && q.size() > 0 && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        p_rd = 5'(q[0]);
        p_wd = $urandom;
      end
      v.i.rv  = pend;
      v.i.rrd = pend ? p_rd : 5'($urandom);
      v.i.rwd = pend ? p_wd : $urandom;
      v.i.ra0 = 5'($urandom_range(0, 7));
      v.i.ra1 = 5'($urandom_range(0, 7));
      v.i.iwa = 5'($urandom_range(0, 7));
      v.i.iwe = 1'($urandom_range(0, 1));
      do_rst  = ($urandom_range(0, 199) == 0);

      if (m_drain) own = v.i.rv ? 2 : 0;
      else         own = v.i.wb_we ? 1 : (v.i.rv ? 2 : 0);
      v.o.rf_wa = (own == 1) ? v.i.wb_wa : (own == 2) ? v.i.rrd : 5'd0;
      v.o.rf_wd = (own == 1) ? v.i.wb_wd : (own == 2) ? v.i.rwd : 32'd0;
      v.o.rf_we = (own != 0) && (v.o.rf_wa != 5'd0);
      v.o.rres  = (own == 2);
      v.o.riss  = (m_cnt < MAX_OUT);
      v.o.hz    = m_busy[v.i.ra0] | m_busy[v.i.ra1] | (v.i.iwe & m_busy[v.i.iwa]);
      v.o.fr    = m_drain;

      rst = do_rst;
      cyc(v, $sformatf("rand%0d", c));
      rst = 1'b0;

      if (do_rst) begin
        model_clear();
      end else begin
        acc    = (own == 2);
        iss_ok = v.i.iv && (m_cnt < MAX_OUT);
        if (acc) begin
          m_busy[v.i.rrd] = 1'b0;
          if (m_cnt > 0) m_cnt--;
          void'(q.pop_front());
          pend = 1'b0;
        end
        if (iss_ok) begin
          m_cnt++;
          q.push_back(int'(v.i.ird));
          if (v.i.ird != 5'd0) m_busy[v.i.ird] = 1'b1;
        end
        if (m_drain) begin
          m_drain  = 1'b0;
          m_starve = 0;
        end else if (v.i.rv && !acc) begin
          m_starve++;
          if (m_starve == STARVE_MAX) m_drain = 1'b1;
        end else begin
          m_starve = 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
